// File: rtl/regfile_mp.sv
// Multi-port register file with zero entry, write bypass,
// write-port priority, conflict flag and a sequenced clear engine.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic [NUM_WR-1:0]        i_we,
    input  logic [NUM_WR*ADDR_W-1:0] i_waddr,
    input  logic [NUM_WR*WIDTH-1:0]  i_wdata,
    input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
    output logic [NUM_RD*WIDTH-1:0]  o_rdata,
    input  logic                     i_clr,
    output logic                     o_busy,
    output logic                     o_wr_conflict
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;
    logic              r_conf;

    logic              w_idle;
    logic [NUM_WR-1:0] w_wen;
    logic              w_conf;

    assign w_idle = (r_state == S_IDLE);

    // Effective enables: writes to a hardwired zero entry vanish entirely
    always_comb begin
        for (int k = 0; k < NUM_WR; k++) begin
            w_wen[k] = i_we[k] && w_idle &&
                       !((ZERO_REG != 0) &&
                         (i_waddr[k*ADDR_W +: ADDR_W] == '0));
        end
    end

    always_comb begin
        w_conf = 1'b0;
        for (int a = 0; a < NUM_WR; a++) begin
            for (int b = a + 1; b < NUM_WR; b++) begin
                if (w_wen[a] && w_wen[b] &&
                    i_waddr[a*ADDR_W +: ADDR_W] ==
                    i_waddr[b*ADDR_W +: ADDR_W]) begin
                    w_conf = 1'b1;
                end
            end
        end
    end

    // Later ports overwrite earlier ones, so the highest index wins
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == S_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (w_wen[k]) begin
                    r_mem[i_waddr[k*ADDR_W +: ADDR_W]] <=
                        i_wdata[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_conf  <= 1'b0;
        end else begin
            r_conf <= w_conf;
            case (r_state)
                S_IDLE: begin
                    if (i_clr) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [WIDTH-1:0]  w_val;

        assign w_ra = i_raddr[r*ADDR_W +: ADDR_W];

        always_comb begin
            w_val = r_mem[w_ra];
            if (BYPASS != 0) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (w_wen[k] &&
                        i_waddr[k*ADDR_W +: ADDR_W] == w_ra) begin
                        w_val = i_wdata[k*WIDTH +: WIDTH];
                    end
                end
            end
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_val = '0;
            end
        end

        assign o_rdata[r*WIDTH +: WIDTH] = w_val;
    end

    assign o_busy        = r_busy;
    assign o_wr_conflict = r_conf;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the pipelined RV32I core and its wider-issue successors. Configurable width, depth, read-port count and write-port count. Adds:
- optional hardwired-zero entry 0
- write-to-read bypass
- deterministic write-port priority with a registered conflict flag
- a sequenced clear engine that zeroes the array one entry per cycle without asserting reset

Parameters:
WIDTH, 32, data width of each entry
DEPTH, 32, number of entries (power of two, >= 2)
ADDR_W, 5, address width, equal to log2(DEPTH)
NUM_RD, 2, number of read ports (>= 1)
NUM_WR, 1, number of write ports (>= 1)
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary entry
BYPASS, 1, 1 = reads return same-cycle write data; 0 = reads return array contents only

Ports:
i_clk  in  1  clock, rising edge
i_rstn  in  1  asynchronous active-low reset
i_we  in  NUM_WR  per-port write enable; bit k belongs to port k
i_waddr  in  NUM_WR*ADDR_W  write addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
i_wdata  in  NUM_WR*WIDTH  write data; port k occupies bits [k*WIDTH +: WIDTH]
i_raddr  in  NUM_RD*ADDR_W  read addresses; port r occupies bits [r*ADDR_W +: ADDR_W]
o_rdata  out  NUM_RD*WIDTH  read data; port r occupies bits [r*WIDTH +: WIDTH]; combinational
i_clr  in  1  request a sequenced clear of the whole array
o_busy  out  1  clear engine active; registered
o_wr_conflict  out  1  one-cycle pulse, registered: two or more enabled write ports targeted the same effective address on the previous edge

Behaviour:
Reset:
- Reset is i_rstn, asynchronous, active-low; clock is i_clk.
- While i_rstn = 0: all entries = 0, FSM = IDLE, clear counter = 0, o_busy = 0, o_wr_conflict = 0.
- o_rdata therefore reads 0 during reset.

Writes:
- Committed on the rising edge for every port k with i_we[k] = 1.
- With ZERO_REG = 1, a write to address 0 is discarded and does not count toward conflicts.
- Priority: when several enabled ports target the same address, the highest-index port wins. Writes to distinct addresses all commit in the same edge.
- o_wr_conflict is set to 1 on the edge following a same-address collision, otherwise cleared to 0. It is evaluated only in IDLE and is 0 in CLEAR.

Reads:
- Purely combinational.
- Address 0 with ZERO_REG = 1 always returns 0, including under bypass.
- With BYPASS = 1 and FSM = IDLE: if any enabled write port targets i_raddr[r], o_rdata[r] returns that port's i_wdata, with the same priority as the write. Otherwise it returns the array entry.
- With BYPASS = 0, or in CLEAR: o_rdata returns the array entry only.

Clear FSM, states IDLE and CLEAR:
- IDLE -> CLEAR on an edge where i_clr = 1. Writes presented on that same edge still commit. Counter <= 0, o_busy <= 1.
- In CLEAR, each edge: entry[counter] <= 0 and counter <= counter + 1.
- On the edge where counter = DEPTH-1: the last entry is zeroed, state -> IDLE, o_busy <= 0.
- o_busy is high for exactly DEPTH cycles.
- In CLEAR: all i_we are ignored (writes dropped), i_clr is ignored, bypass is disabled.
- Entries with index >= counter keep their old values until swept, so reads mid-clear can return stale data.

Reset mid-clear:
- Asynchronous reset aborts the sweep immediately and returns all state to reset values.

Test Plan:
1. Reset, then a write on port 0: addr 5 = 0xDEADBEEF. Next cycle read port 0 addr 5 -> 0xDEADBEEF; read port 1 addr 6 -> 0x00000000.
2. ZERO_REG = 1, write addr 0 = 0x12345678 -> reads of addr 0 return 0 on the same cycle (bypass) and on the next cycle. o_wr_conflict stays 0.
3. NUM_WR = 2, both ports write addr 7 (port 0: 0xAAAA0000, port 1: 0x5555FFFF).
   - Same-cycle bypass read of addr 7 -> 0x5555FFFF.
   - Next cycle array read -> 0x5555FFFF and o_wr_conflict = 1 for one cycle.
   - Then both ports write different addresses 3 and 4 -> both commit, o_wr_conflict = 0.
4. BYPASS = 1: write addr 9 = 0xCAFEF00D with read addr 9 in the same cycle -> o_rdata = 0xCAFEF00D before the edge. With BYPASS = 0 the same stimulus returns the old value 0x00000000 until after the edge.
5. Fill entries 1..31 with index*0x01010101, then pulse i_clr for one cycle.
   - o_busy is high for exactly 32 cycles.
   - A write to addr 10 during the sweep is dropped.
   - After o_busy falls, every entry reads 0.
   - A second i_clr issued mid-sweep does not extend o_busy.
6. Start a clear, then drop i_rstn low asynchronously at sweep cycle 12 (mid-sweep) -> o_busy falls without waiting for a clock edge and all entries read 0. After release, a write to addr 2 = 0x1 commits on the next edge.
